csa_accum_sched: RTL and testbench

- Round-robin scheduler sharing one W-bit carry-save accumulator (sum/carry register pair) between N_REQ requesters.
- Each granted requester streams an operand burst into the accumulator.
- After the burst, the block resolves sum+carry with one carry-propagate add and returns the result with the requester ID.
- Sits in front of the 64-bit CSA datapath and owns its sequencing: clear, accumulate, resolve, hand-off.

---
 rtl/csa_accum_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/csa_accum_sched.sv | 157 +++++++++++++++
 tb/tb_csa_accum_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_accum_pkg.sv
// Shared types and helpers for the carry-save accumulator scheduler.
package csa_accum_pkg;

    localparam int W_DEF     = 64;
    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } state_e;

    // One 3:2 compression step at the default width. The result is {s_next, c_next}.
    // Callers with W < W_DEF pass zero-extended operands and keep the low W bits.
    // Because the carry is a left shift, the bit shifted out of position W is dropped by that truncation.
    function automatic logic [2*W_DEF-1:0] csa_step(input logic [W_DEF-1:0] s,
                                                    input logic [W_DEF-1:0] c,
                                                    input logic [W_DEF-1:0] op);
        logic [W_DEF-1:0] s_n;
        logic [W_DEF-1:0] c_n;
        s_n = s ^ c ^ op;
        c_n = ((s & c) | (s & op) | (c & op)) << 1;
        return {s_n, c_n};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic                     o_any
);
    localparam int IDX_W = $clog2(N_REQ);

    // Scan from the farthest offset down, so the nearest requester to the pointer wins last.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(i_ptr) + k) % N_REQ;
            if (i_req[IDX_W'(j)]) begin
                o_gnt             = '0;
                o_gnt[IDX_W'(j)]  = 1'b1;
                o_idx             = IDX_W'(j);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/csa_accum_sched.sv
// Round-robin scheduler that shares one carry-save accumulator between N_REQ requesters.
// The flow for each grant is: clear, accumulate a burst, resolve with a single carry-propagate add, then hand off.
// Optional macro CSA_ACCUM_CHECK_EN adds a shadow binary accumulator and a sticky chk_err output.
// W must not exceed csa_accum_pkg::W_DEF, because the shared csa_step helper works at that width.
module csa_accum_sched
    import csa_accum_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*W-1:0]       i_op_data,
    input  logic [N_REQ-1:0]         i_op_valid,
    input  logic [N_REQ-1:0]         i_op_last,
    output logic [N_REQ-1:0]         o_op_ready,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [W-1:0]             o_res_data,
    output logic [$clog2(N_REQ)-1:0] o_res_id,
    output logic [CNT_W-1:0]         o_res_cnt,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic                     o_busy,
    output logic                     o_chk_err
);
    localparam int IDX_W = $clog2(N_REQ);

    state_e             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [IDX_W-1:0]   r_id;
    logic [IDX_W-1:0]   r_ptr;
    logic [W-1:0]       r_s;
    logic [W-1:0]       r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_res_data;
    logic [IDX_W-1:0]   r_res_id;
    logic [CNT_W-1:0]   r_res_cnt;
    logic               r_res_valid;

    logic [N_REQ-1:0]   w_arb_gnt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_any;
    logic [W-1:0]       w_ops [N_REQ];
    logic [W-1:0]       w_op;
    logic               w_xfer;
    logic               w_last;
    logic [2*W_DEF-1:0] w_step;
    logic [IDX_W-1:0]   w_ptr_nxt;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ops
        assign w_ops[gi] = i_op_data[gi*W +: W];
    end

    // Only the granted requester's lane matters, and only while accumulating.
    assign w_op      = w_ops[r_id];
    assign w_xfer    = (r_state == ACCUM) && i_op_valid[r_id];
    assign w_last    = i_op_last[r_id];
    assign w_step    = csa_step(W_DEF'(r_s), W_DEF'(r_c), W_DEF'(w_op));
    assign w_ptr_nxt = (r_id == IDX_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;

    assign o_op_ready  = (r_state == ACCUM) ? r_gnt : '0;
    assign o_gnt       = r_gnt;
    assign o_res_data  = r_res_data;
    assign o_res_id    = r_res_id;
    assign o_res_cnt   = r_res_cnt;
    assign o_res_valid = r_res_valid;
    assign o_busy      = (r_state != IDLE);

    // Sequencing FSM: grant, accumulate until op_last, resolve, and hold the result until it is consumed.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_id        <= '0;
            r_ptr       <= '0;
            r_s         <= '0;
            r_c         <= '0;
            r_cnt       <= '0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_res_cnt   <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_any) begin
                        r_gnt   <= w_arb_gnt;
                        r_id    <= w_arb_idx;
                        r_s     <= '0;
                        r_c     <= '0;
                        r_cnt   <= '0;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_xfer) begin
                        r_s   <= w_step[W_DEF +: W];
                        r_c   <= w_step[0 +: W];
                        r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                        if (w_last) r_state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    r_res_data  <= r_s + r_c;
                    r_res_id    <= r_id;
                    r_res_cnt   <= r_cnt;
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_gnt       <= '0;
                        r_ptr       <= w_ptr_nxt;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CSA_ACCUM_CHECK_EN
    logic [W-1:0] r_shadow;
    logic         r_chk_err;

    // Plain binary running sum; the resolved carry-save value must match it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shadow  <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (r_state == IDLE && w_arb_any) r_shadow <= '0;
            else if (w_xfer)                  r_shadow <= r_shadow + w_op;
            if (r_state == RESOLVE && W'(r_s + r_c) != r_shadow) r_chk_err <= 1'b1;
        end
    end

    a_csa_matches_shadow: assert property (@(posedge i_clk) disable iff (i_reset)
        (r_state == RESOLVE) |-> (W'(r_s + r_c) == r_shadow));

    assign o_chk_err = r_chk_err;
`else
    assign o_chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_csa_accum_sched.sv
// Self-checking bench for csa_accum_sched: directed sequences followed by randomized rounds checked against a queue model.
module tb_csa_accum_sched;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int CW = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0]        req = '0;
    logic [N-1:0]        op_valid = '0;
    logic [N-1:0]        op_last = '0;
    logic [N-1:0][W-1:0] op_bus = '0;
    logic                res_ready = 1'b1;
    logic [N-1:0]        op_ready;
    logic [N-1:0]        gnt;
    logic [W-1:0]        res_data;
    logic [1:0]          res_id;
    logic [CW-1:0]       res_cnt;
    logic                res_valid;
    logic                busy;
    logic                chk_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          id;
        logic [63:0] sum;
        int          cnt;
    } exp_t;

    exp_t        expq[$];
    logic [63:0] bq[N][$];
    int          pos[N];
    bit          act[N];
    bit          drop[N];
    int          mptr;

    always #5 clk = ~clk;

    csa_accum_sched #(.N_REQ(N), .W(W), .CNT_W(CW)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req       (req),
        .i_op_data   (op_bus),
        .i_op_valid  (op_valid),
        .i_op_last   (op_last),
        .o_op_ready  (op_ready),
        .o_gnt       (gnt),
        .o_res_data  (res_data),
        .o_res_id    (res_id),
        .o_res_cnt   (res_cnt),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_busy      (busy),
        .o_chk_err   (chk_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present each active requester's current operand; idle lanes get junk that must be ignored.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = act[i] && !drop[i];
            if (act[i]) begin
                op_bus[i]  = bq[i][pos[i]];
                op_last[i] = (pos[i] == bq[i].size() - 1);
            end else begin
                op_bus[i]  = {$urandom, $urandom};
                op_last[i] = 1'($urandom_range(0, 1));
            end
            op_valid[i] = ($urandom_range(0, 9) < 7);
        end
        res_ready = ($urandom_range(0, 9) < 6);
    endtask

    task automatic run_round(input bit sat);
        logic [N-1:0] m;
        exp_t         e;
        int           p;
        int           cyc;
        int           len;
        logic [N-1:0] xf;
        m = sat ? N'(1 << $urandom_range(0, N - 1)) : N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) begin
            bq[i].delete();
            pos[i]  = 0;
            drop[i] = 1'b0;
            act[i]  = m[i];
            if (m[i]) begin
                len = sat ? 300 : $urandom_range(1, 6);
                for (int k = 0; k < len; k++) bq[i].push_back(sat ? 64'd1 : {$urandom, $urandom});
            end
        end
        // Reference order: serve pending requesters by pointer priority, and advance past each one served.
        p = mptr;
        while (m != 0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (p + k) % N;
                if (m[j]) begin
                    e.id  = j;
                    e.sum = 64'd0;
                    foreach (bq[j][q]) e.sum = e.sum + bq[j][q];
                    e.cnt = (bq[j].size() > 255) ? 255 : bq[j].size();
                    expq.push_back(e);
                    m[j] = 1'b0;
                    p    = (j + 1) % N;
                    break;
                end
            end
        end
        mptr = p;
        cyc  = 0;
        drive();
        while (expq.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            chk("gnt_onehot", 64'($countones(gnt) <= 1), 64'd1);
            chk("rdy_in_gnt", 64'(op_ready & ~gnt), 64'd0);
            if (res_valid) begin
                chk("res_data", res_data, expq[0].sum);
                chk("res_id", 64'(res_id), 64'(expq[0].id));
                chk("res_cnt", 64'(res_cnt), 64'(expq[0].cnt));
                if (res_ready) void'(expq.pop_front());
            end
            xf = op_valid & op_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (xf[i] && act[i]) begin
                    if (pos[i] == bq[i].size() - 1) begin
                        act[i] = 1'b0;
                    end else begin
                        pos[i]++;
                        if ($urandom_range(0, 1) == 1) drop[i] = 1'b1;
                    end
                end
            end
            drive();
            cyc++;
        end
        chk("round_drain", 64'(expq.size()), 64'd0);
        expq.delete();
        for (int i = 0; i < N; i++) act[i] = 1'b0;
        req      = '0;
        op_valid = '0;
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rdy", 64'(op_ready), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_data", res_data, 64'd0);
        chk("rst_id", 64'(res_id), 64'd0);
        chk("rst_cnt", 64'(res_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_chk", 64'(chk_err), 64'd0);
        tick();
        reset = 1'b0;

        // Single requester: 5 + 7 + all-ones wraps to 11
        tick();
        req = 4'b0010;
        tick();
        chk("t1_gnt", 64'(gnt), 64'b0010);
        chk("t1_rdy", 64'(op_ready), 64'b0010);
        chk("t1_busy", 64'(busy), 64'd1);
        op_bus[1] = 64'd5; op_valid = 4'b0010;
        tick();
        op_bus[1] = 64'd7;
        tick();
        op_bus[1] = 64'hFFFF_FFFF_FFFF_FFFF; op_last = 4'b0010;
        tick();
        op_valid = '0; op_last = '0; req = '0; res_ready = 1'b0;
        chk("t1_lat_resolve", 64'(res_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(res_valid), 64'd1);
        chk("t1_data", res_data, 64'h0000_0000_0000_000B);
        chk("t1_id", 64'(res_id), 64'd1);
        chk("t1_cnt", 64'(res_cnt), 64'd3);

        // Backpressure: results hold and a new request waits
        req = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_data", res_data, 64'd11);
            chk("bp_id", 64'(res_id), 64'd1);
            chk("bp_cnt", 64'(res_cnt), 64'd3);
            chk("bp_rdy", 64'(op_ready), 64'd0);
            chk("bp_gnt", 64'(gnt), 64'b0010);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(res_valid), 64'd0);
        chk("bp_release_gnt", 64'(gnt), 64'd0);
        tick();
        chk("bp_next_gnt", 64'(gnt), 64'b1000);
        op_bus[3] = 64'd42; op_valid = 4'b1000; op_last = 4'b1000;
        tick();
        op_valid = '0; op_last = '0; req = '0;
        tick();
        chk("bp_next_data", res_data, 64'd42);
        chk("bp_next_id", 64'(res_id), 64'd3);
        tick();

        // Reset in the middle of ACCUM discards the partial sum
        req = 4'b0001;
        tick();
        op_bus[0] = 64'd100; op_valid = 4'b0001;
        tick();
        op_bus[0] = 64'd200;
        tick();
        op_valid = '0; req = '0;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_gnt", 64'(gnt), 64'd0);
        chk("mid_rst_rdy", 64'(op_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_data", res_data, 64'd0);
        chk("mid_rst_id", 64'(res_id), 64'd0);
        tick();
        reset = 1'b0;
        req = 4'b0100;
        tick();
        chk("post_rst_gnt", 64'(gnt), 64'b0100);
        op_bus[2] = 64'd10; op_valid = 4'b0100;
        tick();
        op_bus[2] = 64'd20; op_last = 4'b0100;
        tick();
        op_valid = '0; op_last = '0; req = '0;
        tick();
        chk("post_rst_data", res_data, 64'd30);
        chk("post_rst_id", 64'(res_id), 64'd2);
        chk("post_rst_cnt", 64'(res_cnt), 64'd2);
        tick();
        mptr = 3;

        // Randomized rounds, the first one long enough to saturate the count
        run_round(1'b1);
        for (int r = 0; r < 25; r++) run_round(1'b0);

        chk("chk_err", 64'(chk_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
